// File: rtl/acc_cmd_endpoint.sv
// Accelerator-side command endpoint: parses execute-task commands from CmdIn, runs the kernel,
// returns the finish message on CmdOut. Define ACC_ENDPOINT_PROFILE_EN for the RUN cycle counter.
module acc_cmd_endpoint #(
  parameter int unsigned ACC_BITS = 4,
  parameter int unsigned ACC_ID   = 0,
  parameter int unsigned MAX_ARGS = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cmdin_tvalid,
  output logic                     cmdin_tready,
  input  logic [ACC_BITS-1:0]      cmdin_tdest,
  input  logic [63:0]              cmdin_tdata,
  input  logic                     cmdin_tlast,
  output logic                     cmdout_tvalid,
  input  logic                     cmdout_tready,
  output logic [ACC_BITS-1:0]      cmdout_tid,
  output logic [63:0]              cmdout_tdata,
  output logic                     kernel_start,
  output logic [64*MAX_ARGS-1:0]   kernel_args,
  output logic [7:0]               kernel_num_args,
  input  logic                     kernel_done,
  output logic                     busy,
  output logic                     err
);

  typedef enum logic [3:0] {
    S_IDLE, S_TID, S_PTID, S_ARGS, S_DRAIN, S_START, S_RUN,
    S_FIN0, S_FIN1, S_FIN2, S_FIN3
  } state_e;

  localparam logic [7:0] CMD_EXEC = 8'h01;
`ifdef ACC_ENDPOINT_PROFILE_EN
  localparam logic [7:0] FIN_HDR_HI = 8'h03;
`else
  localparam logic [7:0] FIN_HDR_HI = 8'h02;
`endif

  state_e                     state_q, state_d;
  logic                       cmdin_tready_q;
  logic                       cmdout_tvalid_q;
  logic [63:0]                cmdout_tdata_q, tdata_d;
  logic                       kernel_start_q;
  logic [MAX_ARGS-1:0][63:0]  args_q;
  logic [7:0]                 num_args_q;
  logic [7:0]                 kna_q;
  logic [7:0]                 cnt_q;
  logic [63:0]                tid_q, ptid_q;
  logic                       busy_q, err_q;
  logic                       err_set;
  logic                       in_xfer, out_xfer;
  logic                       hdr_ok, last_arg;
`ifdef ACC_ENDPOINT_PROFILE_EN
  logic [63:0]                cyc_q;
`endif

  logic unused_tdest;
  assign unused_tdest = ^cmdin_tdest;

  assign in_xfer  = cmdin_tvalid && cmdin_tready_q;
  assign out_xfer = cmdout_tvalid_q && cmdout_tready;
  assign hdr_ok   = (cmdin_tdata[7:0] == CMD_EXEC);
  assign last_arg = (cnt_q == num_args_q - 8'd1);

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    case (state_q)
      S_IDLE: if (in_xfer) begin
        if (hdr_ok && !cmdin_tlast) begin
          state_d = S_TID;
        end else begin
          err_set = 1'b1;
          if (!cmdin_tlast) state_d = S_DRAIN;
        end
      end
      S_TID: if (in_xfer) begin
        if (cmdin_tlast) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_PTID;
        end
      end
      S_PTID: if (in_xfer) begin
        if (num_args_q == 8'd0) begin
          if (cmdin_tlast) begin
            state_d = S_START;
          end else begin
            err_set = 1'b1;
            state_d = S_DRAIN;
          end
        end else if (cmdin_tlast) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_ARGS;
        end
      end
      S_ARGS: if (in_xfer) begin
        if (cnt_q >= 8'(MAX_ARGS)) err_set = 1'b1;
        if (last_arg) begin
          if (cmdin_tlast) begin
            state_d = S_START;
          end else begin
            err_set = 1'b1;
            state_d = S_DRAIN;
          end
        end else if (cmdin_tlast) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DRAIN: if (in_xfer && cmdin_tlast) state_d = S_IDLE;
      S_START: state_d = S_RUN;
      S_RUN:   if (kernel_done) state_d = S_FIN0;
      S_FIN0:  if (out_xfer) state_d = S_FIN1;
      S_FIN1:  if (out_xfer) state_d = S_FIN2;
`ifdef ACC_ENDPOINT_PROFILE_EN
      S_FIN2:  if (out_xfer) state_d = S_FIN3;
      S_FIN3:  if (out_xfer) state_d = S_IDLE;
`else
      S_FIN2:  if (out_xfer) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they are glitch-free and all zero in reset.
  always_comb begin
    tdata_d = '0;
    case (state_d)
      S_FIN0:  tdata_d = {48'h0, FIN_HDR_HI, 8'h03};
      S_FIN1:  tdata_d = tid_q;
      S_FIN2:  tdata_d = ptid_q;
`ifdef ACC_ENDPOINT_PROFILE_EN
      S_FIN3:  tdata_d = cyc_q;
`endif
      default: tdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= S_IDLE;
      cmdin_tready_q  <= 1'b0;
      cmdout_tvalid_q <= 1'b0;
      cmdout_tdata_q  <= '0;
      kernel_start_q  <= 1'b0;
      args_q          <= '0;
      num_args_q      <= '0;
      kna_q           <= '0;
      cnt_q           <= '0;
      tid_q           <= '0;
      ptid_q          <= '0;
      busy_q          <= 1'b0;
      err_q           <= 1'b0;
`ifdef ACC_ENDPOINT_PROFILE_EN
      cyc_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      cmdin_tready_q  <= state_d inside {S_IDLE, S_TID, S_PTID, S_ARGS, S_DRAIN};
      cmdout_tvalid_q <= state_d inside {S_FIN0, S_FIN1, S_FIN2, S_FIN3};
      cmdout_tdata_q  <= tdata_d;
      kernel_start_q  <= (state_d == S_START);
      if (err_set) err_q <= 1'b1;
      if (state_d == S_IDLE) busy_q <= 1'b0;
      if (state_d == S_START)
        kna_q <= (num_args_q > 8'(MAX_ARGS)) ? 8'(MAX_ARGS) : num_args_q;
      case (state_q)
        S_IDLE: if (in_xfer && hdr_ok && !cmdin_tlast) begin
          num_args_q <= cmdin_tdata[15:8];
          busy_q     <= 1'b1;
        end
        S_TID: if (in_xfer) tid_q <= cmdin_tdata;
        S_PTID: if (in_xfer) begin
          ptid_q <= cmdin_tdata;
          cnt_q  <= '0;
        end
        S_ARGS: if (in_xfer) begin
          for (int unsigned i = 0; i < MAX_ARGS; i++)
            if (cnt_q == 8'(i)) args_q[i] <= cmdin_tdata;
          cnt_q <= cnt_q + 8'd1;
        end
`ifdef ACC_ENDPOINT_PROFILE_EN
        S_START: cyc_q <= '0;
        S_RUN:   cyc_q <= cyc_q + 64'd1;
`endif
        default: ;
      endcase
    end
  end

  assign cmdin_tready    = cmdin_tready_q;
  assign cmdout_tvalid   = cmdout_tvalid_q;
  assign cmdout_tdata    = cmdout_tdata_q;
  assign cmdout_tid      = ACC_BITS'(ACC_ID);
  assign kernel_start    = kernel_start_q;
  assign kernel_args     = args_q;
  assign kernel_num_args = kna_q;
  assign busy            = busy_q;
  assign err             = err_q;

endmodule
